// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and Gray conversion helpers
// Helpers are fixed at 16 bits, the widest legal counter.
package gray_pkg;

   localparam int DEFAULT_WIDTH = 4;

   function automatic logic [15:0] bin2gray(input logic [15:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [15:0] gray2bin(input logic [15:0] gray);
      logic [15:0] bin;
      bin[15] = gray[15];
      for (int i = 14; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_counter_if.sv
// rtl/gray_counter_if.sv - control and result bundle of the Gray counter
// master drives the controls, slave is the counter itself.
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] bin_out;
   logic [WIDTH-1:0] gray_out;
   logic             tc;
   logic             wrap_pulse;

   modport master (
      output en, up_dn, load, load_val,
      input  bin_out, gray_out, tc, wrap_pulse
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output bin_out, gray_out, tc, wrap_pulse
   );
endinterface

// File: rtl/gray_counter_binary2gray.sv
// rtl/gray_counter_binary2gray.sv - combinational binary to Gray converter
// Pure logic; the caller registers the result.
module binary2gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray output
// Gray is converted from the next binary value so both outputs update on the same edge.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int WRAP  = 1
) (
   input  logic           clk,
   input  logic           rst,
   gray_counter_if.slave  bus
);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic             at_term;

   assign at_term = bus.up_dn ? (bin_q == ALL_ONES) : (bin_q == '0);

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         bin_d = bus.load_val;
      end else if (bus.en) begin
         // In saturate mode the terminal value simply holds.
         if (!(at_term && (WRAP == 0))) begin
            bin_d  = bus.up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
            wrap_d = at_term;
         end
      end
   end

   binary2gray #(.WIDTH(WIDTH)) u_b2g (
      .bin_i  (bin_d),
      .gray_o (gray_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.bin_out    = bin_q;
   assign bus.gray_out   = gray_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.tc         = at_term;

endmodule
